// File: rtl/modclk_monitor.sv
// modclk_monitor: oversampling receive-side checker for MOD/MODN/MODL.
// Measures period, high time, dead time and phase; tracks lock and faults.
module modclk_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 8,
  parameter int TOL         = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             CLK_IN,
  input  logic             RESET,
  input  logic             MOD_IN,
  input  logic             MODN_IN,
  input  logic             MODL_IN,
  input  logic             CLR_ERR,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic [CNT_W-1:0] DEAD_TIME,
  output logic [CNT_W-1:0] PHASE,
  output logic             MEAS_VALID,
  output logic             LOCKED,
  output logic             OVERLAP_ERR,
  output logic             MISSING_ERR
);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_TRACK,
    S_LOCK
  } state_t;

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] ONES  = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LC_C  = MW'(LOCK_COUNT);

  // bit 0 = MOD, bit 1 = MODN, bit 2 = MODL
  logic [SYNC_STAGES-1:0][2:0] r_sync;
  logic [2:0]                  r_prev;
  logic [2:0]                  w_s;
  logic [2:0]                  w_rise;
  logic                        w_mod_rise;
  logic                        w_mod_fall;
  logic                        w_modn_rise;
  logic                        w_modl_rise;
  logic                        w_ovl_ev;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_fall;
  logic [CNT_W-1:0] r_dn;
  logic [CNT_W-1:0] r_ph;
  logic             r_fall_v;
  logic             r_dn_v;
  logic             r_ph_v;
  logic             w_fall_seen;
  logic [CNT_W-1:0] w_fall_stamp;
  logic [CNT_W-1:0] w_hi_val;
  logic [CNT_W-1:0] w_dn_val;
  logic [CNT_W-1:0] w_ph_val;

  state_t           r_state;
  state_t           w_state_n;
  logic [MW-1:0]    r_match;
  logic [MW-1:0]    w_match_n;
  logic [MW-1:0]    w_match_inc;
  logic             r_first;
  logic             w_first_n;
  logic             w_latch;
  logic             w_miss_ev;
  logic [CNT_W-1:0] w_diff;
  logic             w_in_tol;
  logic             w_timeout;

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_dead;
  logic [CNT_W-1:0] r_phase;
  logic             r_valid;
  logic             r_locked;
  logic             r_ovl;
  logic             r_miss;

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], MODL_IN, MODN_IN, MOD_IN};
      r_prev <= w_s;
    end
  end

  assign w_s         = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_s & ~r_prev;
  assign w_mod_rise  = w_rise[0];
  assign w_modn_rise = w_rise[1];
  assign w_modl_rise = w_rise[2];
  assign w_mod_fall  = ~w_s[0] & r_prev[0];
  assign w_ovl_ev    = w_s[0] & w_s[1];

  // A MODN rise in the same cycle as the MOD fall counts (dead time 0)
  assign w_fall_seen  = r_fall_v | w_mod_fall;
  assign w_fall_stamp = w_mod_fall ? r_cnt : r_fall;

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      r_cnt    <= '0;
      r_fall   <= '0;
      r_dn     <= '0;
      r_ph     <= '0;
      r_fall_v <= 1'b0;
      r_dn_v   <= 1'b0;
      r_ph_v   <= 1'b0;
    end else begin
      if (w_mod_rise) begin
        r_cnt <= ONE;
      end else if (r_cnt != ONES) begin
        r_cnt <= r_cnt + ONE;
      end
      if (w_mod_rise) begin
        r_fall_v <= 1'b0;
        r_dn_v   <= 1'b0;
        r_ph_v   <= w_modl_rise;
        r_ph     <= '0;
      end else begin
        if (w_mod_fall && !r_fall_v) begin
          r_fall_v <= 1'b1;
          r_fall   <= r_cnt;
        end
        if (w_modn_rise && w_fall_seen && !r_dn_v) begin
          r_dn_v <= 1'b1;
          r_dn   <= r_cnt - w_fall_stamp;
        end
        if (w_modl_rise && !r_ph_v) begin
          r_ph_v <= 1'b1;
          r_ph   <= r_cnt;
        end
      end
    end
  end

  assign w_hi_val = r_fall_v ? r_fall : ONES;
  assign w_dn_val = r_dn_v ? r_dn : ONES;
  assign w_ph_val = r_ph_v ? r_ph : ONES;

  assign w_diff = (r_cnt >= r_period) ? (r_cnt - r_period)
                                      : (r_period - r_cnt);
  assign w_in_tol    = (w_diff <= TOL_C);
  assign w_timeout   = (r_cnt >= TO_C) && !w_mod_rise;
  assign w_match_inc = r_match + MW'(1);

  always_comb begin
    w_state_n = r_state;
    w_match_n = r_match;
    w_first_n = r_first;
    w_latch   = 1'b0;
    w_miss_ev = 1'b0;
    unique case (r_state)
      S_SEARCH: begin
        if (w_mod_rise) begin
          w_state_n = S_TRACK;
          w_match_n = '0;
          w_first_n = 1'b1;
        end
      end
      S_TRACK: begin
        if (w_mod_rise) begin
          w_latch   = 1'b1;
          w_first_n = 1'b0;
          if (r_first) begin
            w_match_n = '0;
          end else if (w_in_tol) begin
            w_match_n = w_match_inc;
            if (w_match_inc >= LC_C) begin
              w_state_n = S_LOCK;
            end
          end else begin
            w_match_n = '0;
          end
        end else if (w_timeout) begin
          w_state_n = S_SEARCH;
          w_match_n = '0;
          w_miss_ev = 1'b1;
        end
      end
      S_LOCK: begin
        if (w_mod_rise) begin
          w_latch = 1'b1;
          if (!w_in_tol) begin
            w_state_n = S_TRACK;
            w_match_n = '0;
          end
        end else if (w_timeout) begin
          w_state_n = S_SEARCH;
          w_match_n = '0;
          w_miss_ev = 1'b1;
        end
      end
      default: begin
        w_state_n = S_SEARCH;
        w_match_n = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_SEARCH;
      r_match  <= '0;
      r_first  <= 1'b0;
      r_period <= '0;
      r_high   <= '0;
      r_dead   <= '0;
      r_phase  <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_ovl    <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_match  <= w_match_n;
      r_first  <= w_first_n;
      r_valid  <= w_latch;
      r_locked <= (w_state_n == S_LOCK);
      if (w_latch) begin
        r_period <= r_cnt;
        r_high   <= w_hi_val;
        r_dead   <= w_dn_val;
        r_phase  <= w_ph_val;
      end
      // A new fault in the clearing cycle still sets the flag
      r_ovl  <= (r_ovl & ~CLR_ERR) | w_ovl_ev;
      r_miss <= (r_miss & ~CLR_ERR) | w_miss_ev;
    end
  end

  assign PERIOD      = r_period;
  assign HIGH_TIME   = r_high;
  assign DEAD_TIME   = r_dead;
  assign PHASE       = r_phase;
  assign MEAS_VALID  = r_valid;
  assign LOCKED      = r_locked;
  assign OVERLAP_ERR = r_ovl;
  assign MISSING_ERR = r_miss;

endmodule

// File: tb/tb_modclk_monitor.sv
// tb_modclk_monitor: randomized stimulus for modclk_monitor checked
// every cycle against an event-level model of the measurements.
module tb_modclk_monitor;

  localparam int CW   = 16;
  localparam int SS   = 2;
  localparam int LC   = 8;
  localparam int TOL  = 2;
  localparam int TO   = 1024;
  localparam int ALL1 = 65535;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          mod_i  = 1'b0;
  logic          modn_i = 1'b0;
  logic          modl_i = 1'b0;
  logic          clr    = 1'b0;
  logic [CW-1:0] period, high_time, dead_time, phase;
  logic          meas_valid, locked, overlap_err, missing_err;

  modclk_monitor #(
    .CNT_W(CW), .SYNC_STAGES(SS), .LOCK_COUNT(LC),
    .TOL(TOL), .TIMEOUT(TO)
  ) dut (
    .CLK_IN(clk),
    .RESET(rst),
    .MOD_IN(mod_i),
    .MODN_IN(modn_i),
    .MODL_IN(modl_i),
    .CLR_ERR(clr),
    .PERIOD(period),
    .HIGH_TIME(high_time),
    .DEAD_TIME(dead_time),
    .PHASE(phase),
    .MEAS_VALID(meas_valid),
    .LOCKED(locked),
    .OVERLAP_ERR(overlap_err),
    .MISSING_ERR(missing_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  // One entry per driven MOD rise: the cycle its effect must appear,
  // plus the intra-period stamps of the period that rise closes.
  typedef struct {
    int c;
    int hi;
    int dn;
    int ph;
  } rise_t;

  rise_t rq[$];
  bit    ov_at[int];
  bit    clr_at[int];

  int  hist[$];
  bit  m_track = 0;
  int  m_last = 0;
  int  m_per = 0, m_hi = 0, m_dn = 0, m_ph = 0;
  bit  m_lock = 0, m_ovl = 0, m_miss = 0;
  int  n_meas = 0;
  bit  seen_lock = 0;
  int  meas_at_lock = -1;

  function automatic int tail_run();
    int n;
    int d;
    n = 0;
    for (int i = hist.size() - 1; i >= 1; i--) begin
      d = hist[i] - hist[i-1];
      if (d < 0) d = -d;
      if (d > TOL) break;
      n++;
    end
    return n;
  endfunction

  always @(negedge clk) begin
    bit    exp_mv;
    rise_t ev;
    exp_mv = 1'b0;
    if (rst) begin
      rq.delete();
      ov_at.delete();
      clr_at.delete();
      hist.delete();
      m_track = 0; m_last = 0;
      m_per = 0; m_hi = 0; m_dn = 0; m_ph = 0;
      m_lock = 0; m_ovl = 0; m_miss = 0;
      n_meas = 0;
    end else begin
      if (clr_at.exists(cyc)) begin
        m_ovl  = 0;
        m_miss = 0;
      end
      if (ov_at.exists(cyc)) m_ovl = 1;
      if (rq.size() > 0 && rq[0].c == cyc) begin
        ev = rq.pop_front();
        if (m_track) begin
          m_per = cyc - m_last;
          m_hi  = (ev.hi < 0) ? ALL1 : ev.hi;
          m_dn  = (ev.hi < 0 || ev.dn < 0) ? ALL1 : ev.dn;
          m_ph  = (ev.ph < 0) ? ALL1 : ev.ph;
          hist.push_back(m_per);
          m_lock = (tail_run() >= LC);
          exp_mv = 1'b1;
        end else begin
          hist.delete();
        end
        m_track = 1;
        m_last  = cyc;
      end else if (m_track && (cyc - m_last) == TO) begin
        m_track = 0;
        m_lock  = 0;
        m_miss  = 1;
        hist.delete();
      end
      if (meas_valid) n_meas++;
      if (locked && !seen_lock) begin
        seen_lock    = 1;
        meas_at_lock = n_meas;
      end
    end
    chk("meas_valid", int'(meas_valid), int'(exp_mv));
    chk("period", int'(period), m_per);
    chk("high_time", int'(high_time), m_hi);
    chk("dead_time", int'(dead_time), m_dn);
    chk("phase", int'(phase), m_ph);
    chk("locked", int'(locked), int'(m_lock));
    chk("overlap_err", int'(overlap_err), int'(m_ovl));
    chk("missing_err", int'(missing_err), int'(m_miss));
  end

  int p_hi = -1, p_dn = -1, p_ph = -1;

  // Drive one MOD period tick by tick; MODN and MODL pulses last 2 ticks.
  // ov: tick of an extra 1-tick MODN glitch, clrt: tick of a CLR_ERR pulse.
  task automatic drive_period(int P, int H, int D, int Ph,
                              int ov = -1, int clrt = -1, int cut = -1);
    int n;
    int t;
    rise_t r;
    n = (cut < 0) ? P : cut;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t = cyc + 1;
      mod_i  = (i < H);
      modn_i = ((D >= 0) && (i >= H + D) && (i < H + D + 2)) || (i == ov);
      modl_i = (Ph >= 0) && (i >= Ph) && (i < Ph + 2);
      clr    = (i == clrt);
      if (i == 0) begin
        r.c = t + SS; r.hi = p_hi; r.dn = p_dn; r.ph = p_ph;
        rq.push_back(r);
      end
      if (i == ov) ov_at[t + SS] = 1'b1;
      if (i == clrt) clr_at[t] = 1'b1;
    end
    p_hi = H; p_dn = D; p_ph = Ph;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mod_i = 0; modn_i = 0; modl_i = 0; clr = 0;
    end
  endtask

  task automatic steady(int n);
    for (int i = 0; i < n; i++) drive_period(25, 12, 2, 6);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, P, H, D, Ph, ov, ct;
    repeat (3) @(posedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_locked", int'(locked), 0);
    #3 rst = 1'b0;

    // steady state and first lock
    steady(12);
    chk("lit_period", int'(period), 25);
    chk("lit_high", int'(high_time), 12);
    chk("lit_dead", int'(dead_time), 2);
    chk("lit_phase", int'(phase), 6);
    chk("lit_locked", int'(locked), 1);
    chk("lit_lock_at_meas", meas_at_lock, 9);

    // jitter
    drive_period(26, 12, 2, 6);
    steady(3);
    chk("lit_jit26_locked", int'(locked), 1);
    drive_period(30, 12, 2, 6);
    steady(1);
    chk("lit_jit30_drop", int'(locked), 0);
    steady(8);
    chk("lit_relock_pre", int'(locked), 0);
    steady(1);
    chk("lit_relock", int'(locked), 1);

    // overlap, clear, clear-vs-set
    drive_period(25, 12, 2, 6, 4);
    steady(2);
    chk("lit_ovl_set", int'(overlap_err), 1);
    drive_period(25, 12, 2, 6, -1, 3);
    chk("lit_ovl_clr", int'(overlap_err), 0);
    drive_period(25, 12, 2, 6, 4, 4 + SS);
    chk("lit_ovl_setwins", int'(overlap_err), 1);
    drive_period(25, 12, 2, 6, -1, 3);
    chk("lit_ovl_clr2", int'(overlap_err), 0);

    // simultaneous edges
    drive_period(25, 12, 0, 0);
    steady(1);
    chk("lit_dead0", int'(dead_time), 0);
    chk("lit_phase0", int'(phase), 0);
    chk("lit_dead0_noovl", int'(overlap_err), 0);

    // missing MODL stamp
    drive_period(25, 12, 2, -1);
    steady(1);
    chk("lit_phase_ffff", int'(phase), ALL1);
    chk("lit_phase_ffff_hi", int'(high_time), 12);

    // missing clock
    idle(1100);
    chk("lit_miss_err", int'(missing_err), 1);
    chk("lit_miss_unlock", int'(locked), 0);
    chk("lit_miss_period", int'(period), 25);
    drive_period(25, 12, 2, 6, -1, 3);
    steady(10);
    chk("lit_miss_relock", int'(locked), 1);
    chk("lit_miss_clr", int'(missing_err), 0);

    // randomized periods
    base = $urandom_range(20, 40);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) base = $urandom_range(20, 40);
      P  = base + int'($urandom_range(0, 4)) - 2;
      H  = $urandom_range(2, P - 6);
      D  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, P - 3 - H));
      Ph = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, P - 3));
      ov = ($urandom_range(0, 7) == 0) ? 0 : -1;
      ct = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, P - 1)) : -1;
      drive_period(P, H, D, Ph, ov, ct);
    end

    // asynchronous reset mid-period while locked
    steady(12);
    chk("lit_prerst_locked", int'(locked), 1);
    drive_period(25, 12, 2, 6, -1, -1, 10);
    @(posedge clk);
    #3;
    rst = 1'b1;
    mod_i = 0; modn_i = 0; modl_i = 0; clr = 0;
    #1;
    chk("lit_arst_period", int'(period), 0);
    chk("lit_arst_high", int'(high_time), 0);
    chk("lit_arst_dead", int'(dead_time), 0);
    chk("lit_arst_phase", int'(phase), 0);
    chk("lit_arst_valid", int'(meas_valid), 0);
    chk("lit_arst_locked", int'(locked), 0);
    chk("lit_arst_ovl", int'(overlap_err), 0);
    chk("lit_arst_miss", int'(missing_err), 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    p_hi = -1; p_dn = -1; p_ph = -1;
    steady(1);
    chk("lit_postrst_meas0", n_meas, 0);
    steady(1);
    chk("lit_postrst_meas1", n_meas, 1);
    chk("lit_postrst_period", int'(period), 25);
    steady(2);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modclk_monitor.md
Name: modclk_monitor

Overview:
- Receive-side checker for the three non-overlapping modulation clocks (MOD, MODN, MODL) driven to the MBI pins.
- Oversamples all three with a fast system clock and measures, in system-clock cycles:
  - MOD period
  - MOD high time
  - MOD-fall to MODN-rise dead time
  - MOD-rise to MODL-rise phase offset
- Tracks frequency lock and flags overlap and missing-clock faults.
- Used on a loopback or monitor board so the shift-register clock generator settings can be checked in hardware.

Parameters:
- CNT_W, 16: width of all measurement counters and outputs.
- SYNC_STAGES, 2: flip-flop synchronizer depth per input (min 2).
- LOCK_COUNT, 8: consecutive in-tolerance periods required to assert LOCKED.
- TOL, 2: allowed |period - previous period| in cycles that still counts as a match.
- TIMEOUT, 1024: cycles without a MOD rise before a missing-clock fault.

Ports:
- CLK_IN, input, 1: system sampling clock (e.g. 100 MHz USER_CLOCK).
- RESET, input, 1: asynchronous, active-high reset.
- MOD_IN, input, 1: asynchronous MOD clock from pin.
- MODN_IN, input, 1: asynchronous MODN clock from pin.
- MODL_IN, input, 1: asynchronous MODL clock from pin.
- CLR_ERR, input, 1: synchronous pulse; clears the sticky error flags.
- PERIOD, output, CNT_W: cycles between the last two MOD rises.
- HIGH_TIME, output, CNT_W: MOD high duration in the last period.
- DEAD_TIME, output, CNT_W: cycles from MOD fall to next MODN rise.
- PHASE, output, CNT_W: cycles from MOD rise to next MODL rise.
- MEAS_VALID, output, 1: one-cycle pulse when a new measurement set is latched.
- LOCKED, output, 1: frequency locked.
- OVERLAP_ERR, output, 1: sticky; synchronized MOD and MODN were high in the same cycle.
- MISSING_ERR, output, 1: sticky; MOD timeout occurred.

Behaviour:
- Reset:
  - All outputs are 0 while RESET is high, taking effect immediately (async).
  - The FSM enters SEARCH.
  - Synchronizers, counters and the match count are cleared.
  - Reset mid-measurement discards partial results.
- Input path:
  - Each input passes through SYNC_STAGES flops, then one edge-detect flop.
  - An edge becomes visible SYNC_STAGES+1 cycles after the pin transition.
  - All timings below are between detected edges.
  - Equal pipeline depth on all inputs means relative measurements are exact to ±1 cycle of sampling.
- Cycle counter:
  - Free-running count since the last detected MOD rise; saturates at all-ones (no wrap).
  - On each MOD rise, intra-period stamps are taken relative to that rise:
    - MOD fall, giving HIGH_TIME.
    - First MODN rise after the MOD fall, giving DEAD_TIME = stamp(MODN rise) - stamp(MOD fall).
    - First MODL rise, giving PHASE.
  - Any stamp not seen before the next MOD rise reports all-ones.
- Latching:
  - On a detected MOD rise (other than the first after SEARCH), PERIOD, HIGH_TIME, DEAD_TIME and PHASE update together.
  - MEAS_VALID pulses in the following cycle.
  - PERIOD = t(rise n) - t(rise n-1).
- FSM states:
  - SEARCH: waits for the first MOD rise, then goes to TRACK with match count 0. No MEAS_VALID is produced.
  - TRACK:
    - The second rise gives the first measurement, which is stored with no comparison.
    - Each later rise compares the new PERIOD with the previous one.
    - Difference ≤ TOL: increment the match count. Otherwise: match count = 0.
    - Match count reaching LOCK_COUNT moves to LOCK.
    - With defaults, LOCKED rises on the 10th MOD rise, in the same cycle as that MEAS_VALID.
  - LOCK: LOCKED = 1. An out-of-tolerance period drops to TRACK with match count 0, and LOCKED = 0 in the cycle of that MEAS_VALID.
  - Timeout in TRACK or LOCK (counter reaches TIMEOUT with no MOD rise):
    - Go to SEARCH.
    - Set LOCKED = 0 and MISSING_ERR = 1.
    - Measurement outputs hold their last values.
- Errors:
  - OVERLAP_ERR sets in any state when synchronized MOD and MODN are both 1 in the same cycle.
  - Errors are cleared only by CLR_ERR or RESET.
  - If CLR_ERR and a new error event occur in the same cycle, set wins.
- Simultaneous edges:
  - MOD rise and MODL rise in the same cycle give PHASE = 0.
  - MOD fall and MODN rise in the same cycle give DEAD_TIME = 0, with no overlap error.

Test Plan:
- Steady state: CLK_IN 100 MHz; MOD period 25 cycles, high 12; MODN rises 2 cycles after MOD falls; MODL rises 6 cycles after MOD rises. Required: PERIOD=25, HIGH_TIME=12, DEAD_TIME=2, PHASE=6, MEAS_VALID once per period starting at the 2nd rise, LOCKED=1 from the 10th rise.
- Jitter: once locked, one period of 26 keeps LOCKED=1. A period of 30 drops LOCKED in that MEAS_VALID cycle; re-lock occurs exactly 8 in-tolerance periods later.
- Overlap: MODN driven high for 1 cycle while MOD is high gives OVERLAP_ERR=1 and holds it. A CLR_ERR pulse clears it. CLR_ERR coincident with another overlap leaves OVERLAP_ERR=1.
- Missing clock: stop MOD while locked. After 1024 cycles: MISSING_ERR=1, LOCKED=0, PERIOD still 25. Restarting MOD re-locks from SEARCH.
- Missing stamp: MODL held low leads to PHASE=0xFFFF on the next MEAS_VALID, while the other outputs stay correct.
- Reset: assert RESET asynchronously mid-period while locked. All outputs go to 0 without waiting for a CLK_IN edge. After release, the first MEAS_VALID occurs only at the 2nd MOD rise.
